// File: rtl/mux_select_bank_if.sv
// Shared 32-entry data set, selects and combinational/registered results of the mux bank.
interface mux_select_bank_if #(
    parameter int unsigned N = 32
);
    logic [N-1:0] d [32];
    logic         sel2;
    logic [3:0]   sel16;
    logic [4:0]   sel32;
    logic [N-1:0] y2;
    logic [N-1:0] y16;
    logic [N-1:0] y32;
    logic [N-1:0] q2;
    logic [N-1:0] q16;
    logic [N-1:0] q32;

    modport master (
        output d, sel2, sel16, sel32,
        input  y2, y16, y32, q2, q16, q32
    );

    modport slave (
        input  d, sel2, sel16, sel32,
        output y2, y16, y32, q2, q16, q32
    );
endinterface

// File: rtl/mux_select_bank.sv
// Bank of 2:1, 16:1 and 32:1 binary-select muxes built as trees of 2:1 leaf cells,
// each with a combinational result and a one-cycle registered copy.
module mux_select_bank #(
    parameter int unsigned N = 32
) (
    input logic           clk,
    input logic           rst,
    mux_select_bank_if.slave bus
);

    typedef logic [N-1:0] word_t;

    // Leaf cell; the conditional operator keeps standard X propagation on the select.
    function automatic word_t mux2(input logic s, input word_t a, input word_t b);
        return s ? b : a;
    endfunction

    function automatic word_t mux4(input logic [1:0] s, input logic [3:0][N-1:0] v);
        return mux2(s[1], mux2(s[0], v[0], v[1]), mux2(s[0], v[2], v[3]));
    endfunction

    function automatic word_t mux8(input logic [2:0] s, input logic [7:0][N-1:0] v);
        return mux2(s[2], mux4(s[1:0], v[3:0]), mux4(s[1:0], v[7:4]));
    endfunction

    function automatic word_t mux16(input logic [3:0] s, input logic [15:0][N-1:0] v);
        return mux2(s[3], mux8(s[2:0], v[7:0]), mux8(s[2:0], v[15:8]));
    endfunction

    function automatic word_t mux32(input logic [4:0] s, input logic [31:0][N-1:0] v);
        return mux2(s[4], mux16(s[3:0], v[15:0]), mux16(s[3:0], v[31:16]));
    endfunction

    logic [31:0][N-1:0] d_p;
    word_t y2, y16, y32;
    word_t q2_q, q16_q, q32_q;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            d_p[i] = bus.d[i];
        end
    end

    always_comb begin
        y2  = mux2(bus.sel2, d_p[0], d_p[1]);
        y16 = mux16(bus.sel16, d_p[15:0]);
        y32 = mux32(bus.sel32, d_p);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q2_q  <= '0;
            q16_q <= '0;
            q32_q <= '0;
        end else begin
            q2_q  <= y2;
            q16_q <= y16;
            q32_q <= y32;
        end
    end

    assign bus.y2  = y2;
    assign bus.y16 = y16;
    assign bus.y32 = y32;
    assign bus.q2  = q2_q;
    assign bus.q16 = q16_q;
    assign bus.q32 = q32_q;

endmodule

// File: tb/tb_mux_select_bank.sv
// Directed and random checks of the mux bank: combinational selects, registered copies, reset.
module tb_mux_select_bank;

    localparam int unsigned N = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [N-1:0] dv [32];
    logic [N-1:0] e2, e16, e32;

    mux_select_bank_if #(.N(N)) bus ();

    mux_select_bank #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_d();
        for (int i = 0; i < 32; i++) bus.d[i] = dv[i];
    endtask

    initial begin
        for (int i = 0; i < 32; i++) dv[i] = $urandom;
        drive_d();
        bus.sel2  = 1'b0;
        bus.sel16 = 4'd0;
        bus.sel32 = 5'd0;

        // Reset with no clock edge yet
        #1 rst = 1'b1;
        #1;
        check("rst_q2", bus.q2, '0);
        check("rst_q16", bus.q16, '0);
        check("rst_q32", bus.q32, '0);

        // 2:1 directed
        dv[0] = 32'h1234_5678;
        dv[1] = 32'hDEAD_BEEF;
        drive_d();
        bus.sel2 = 1'b0;
        #1 check("y2_sel0", bus.y2, 32'h1234_5678);
        bus.sel2 = 1'b1;
        #1 check("y2_sel1", bus.y2, 32'hDEAD_BEEF);

        // 16:1 exhaustive, upper inputs random
        for (int i = 0; i < 16; i++) dv[i] = i * 32'h0101_0101 + 32'd7;
        for (int i = 16; i < 32; i++) dv[i] = $urandom;
        drive_d();
        for (int s = 0; s < 16; s++) begin
            bus.sel16 = 4'(s);
            #10 check($sformatf("y16_sel%0d", s), bus.y16, 32'(s) * 32'h0101_0101 + 32'd7);
        end

        // 32:1 exhaustive
        for (int i = 0; i < 32; i++) dv[i] = $urandom;
        drive_d();
        for (int s = 0; s < 32; s++) begin
            bus.sel32 = 5'(s);
            #1 check($sformatf("y32_sel%0d", s), bus.y32, dv[s]);
        end

        // Random iterations across all three muxes
        for (int it = 0; it < 1000; it++) begin
            for (int i = 0; i < 32; i++) dv[i] = $urandom;
            drive_d();
            bus.sel2  = 1'($urandom_range(0, 1));
            bus.sel16 = 4'($urandom_range(0, 15));
            bus.sel32 = 5'($urandom_range(0, 31));
            #1;
            check("rnd_y2", bus.y2, bus.sel2 ? dv[1] : dv[0]);
            check("rnd_y16", bus.y16, dv[bus.sel16]);
            check("rnd_y32", bus.y32, dv[bus.sel32]);
        end
        check("rnd_q32_in_rst", bus.q32, '0);

        // Registered path: release reset, one edge
        @(negedge clk);
        rst       = 1'b0;
        bus.sel2  = 1'b1;
        bus.sel16 = 4'd9;
        bus.sel32 = 5'd5;
        dv[5]     = 32'hA5A5_A5A5;
        drive_d();
        e2  = dv[1];
        e16 = dv[9];
        #1 check("q32_before_edge", bus.q32, '0);
        @(negedge clk);
        check("q32_first_edge", bus.q32, 32'hA5A5_A5A5);
        check("q2_first_edge", bus.q2, e2);
        check("q16_first_edge", bus.q16, e16);

        // Input change without select change
        bus.sel16 = 4'd3;
        dv[3]     = '0;
        drive_d();
        @(negedge clk);
        check("q16_d3_zero", bus.q16, '0);
        dv[3] = 32'hFFFF_FFFF;
        drive_d();
        #1;
        check("y16_d3_follow", bus.y16, 32'hFFFF_FFFF);
        check("q16_d3_hold", bus.q16, '0);
        @(negedge clk);
        check("q16_d3_edge", bus.q16, 32'hFFFF_FFFF);

        // Reset mid-operation between edges
        rst = 1'b1;
        #1;
        check("mid_rst_q16", bus.q16, '0);
        check("mid_rst_q2", bus.q2, '0);
        check("mid_rst_q32", bus.q32, '0);
        dv[3] = 32'h0000_1234;
        drive_d();
        #1 check("mid_rst_y16", bus.y16, 32'h0000_1234);
        @(negedge clk);
        check("mid_rst_q16_hold", bus.q16, '0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_q16", bus.q16, 32'h0000_1234);
        e32 = dv[5];
        check("post_rst_q32", bus.q32, e32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
